// File: rtl/max7219_chain.sv
// max7219_chain: drives a daisy-chain of NUM_DEV MAX7219 LED drivers.
// After a power-up wait it programs every device (shutdown, test off, scan
// limit, decode off, intensity, run), then refreshes digits 1..8 forever.
// The digits come from display_value, which is snapshotted once per pass.
// If intensity changes, a broadcast intensity frame is sent at the next
// pass boundary. A reinit request reruns the init sequence at the next
// frame boundary.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   display_value   8 hex nibbles per device (device d = bits [32d+31:32d])
//   intensity       brightness code written to register 0xA
//   reinit          single-cycle request to rerun the init sequence
//   din, sck, load  serial bus to the first device in the chain
//   busy            high from load fall through load rise
//   pass_done       one-cycle pulse when the digit-8 frame has been latched
module max7219_chain #(
  parameter int NUM_DEV    = 2,
  parameter int CLK_DIV    = 128,
  parameter int POR_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*NUM_DEV-1:0] display_value,
  input  logic [3:0]            intensity,
  input  logic                  reinit,
  output logic                  din,
  output logic                  sck,
  output logic                  load,
  output logic                  busy,
  output logic                  pass_done
);
  localparam int HALF = CLK_DIV / 2;
  localparam int NB   = 16 * NUM_DEV;
  localparam int VW   = 32 * NUM_DEV;
  localparam int DW   = $clog2(CLK_DIV);
  localparam int BW   = $clog2(NB);
  localparam int PW   = $clog2(POR_CYCLES + 1);

  // Frame codes: 0..5 init steps, 6 intensity update, 7..14 digits 1..8.
  localparam logic [3:0] F_INIT_LAST = 4'd5;
  localparam logic [3:0] F_INTENS    = 4'd6;
  localparam logic [3:0] F_DIG1      = 4'd7;
  localparam logic [3:0] F_DIG8      = 4'd14;

  typedef enum logic [1:0] {S_POR, S_INIT, S_IDLE_GAP, S_REFRESH} state_t;
  typedef enum logic [1:0] {PH_LEAD, PH_SHIFT, PH_TAIL} phase_t;

  state_t        st_q, st_d;
  phase_t        ph_q, ph_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] por_q, por_d;
  logic [3:0]    idx_q, idx_d;
  logic          pend_q, pend_d;
  logic [3:0]    prog_q, prog_d;
  logic [NB-1:0] sr_q, sr_d;
  logic [VW-1:0] disp_q, disp_d;
  logic          din_q, din_d, sck_q, sck_d, load_q, load_d;
  logic          busy_q, busy_d, pd_q, pd_d;
  logic          start;
  logic [3:0]    nxt;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h7E;  4'h1: seg7 = 7'h30;  4'h2: seg7 = 7'h6D;  4'h3: seg7 = 7'h79;
      4'h4: seg7 = 7'h33;  4'h5: seg7 = 7'h5B;  4'h6: seg7 = 7'h5F;  4'h7: seg7 = 7'h70;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h7B;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h1F;
      4'hC: seg7 = 7'h4E;  4'hD: seg7 = 7'h3D;  4'hE: seg7 = 7'h4F;  default: seg7 = 7'h47;
    endcase
  endfunction

  // Device NUM_DEV-1 occupies the top word so it is shifted out first.
  function automatic logic [NB-1:0] build_frame(input logic [3:0] code,
                                                input logic [3:0] inten,
                                                input logic [VW-1:0] src);
    logic [NB-1:0] f;
    logic [15:0]   w;
    logic [3:0]    dig;
    f   = '0;
    dig = code - F_INTENS;
    for (int d = 0; d < NUM_DEV; d++) begin
      case (code)
        4'd0:           w = 16'h0C00;
        4'd1:           w = 16'h0F00;
        4'd2:           w = 16'h0B07;
        4'd3:           w = 16'h0900;
        4'd4, F_INTENS: w = {8'h0A, 4'h0, inten};
        F_INIT_LAST:    w = 16'h0C01;
        default:        w = {4'h0, dig, 1'b0, seg7(src[32*d + 4*(int'(dig) - 1) +: 4])};
      endcase
      f[16*d +: 16] = w;
    end
    return f;
  endfunction

  always_comb begin
    st_d   = st_q;
    ph_d   = ph_q;
    div_d  = div_q;
    bit_d  = bit_q;
    por_d  = por_q;
    idx_d  = idx_q;
    pend_d = pend_q | reinit;
    prog_d = prog_q;
    sr_d   = sr_q;
    disp_d = disp_q;
    din_d  = 1'b0;
    sck_d  = 1'b0;
    load_d = 1'b1;
    busy_d = 1'b0;
    pd_d   = 1'b0;
    start  = 1'b0;
    nxt    = idx_q;

    case (st_q)
      S_POR: begin
        pend_d = 1'b0;
        if (por_q == PW'(POR_CYCLES - 1)) begin
          start = 1'b1;
          nxt   = 4'd0;
        end else begin
          por_d = por_q + PW'(1);
        end
      end
      S_INIT, S_REFRESH: begin
        load_d = 1'b0;
        busy_d = 1'b1;
        case (ph_q)
          PH_LEAD: begin
            ph_d  = PH_SHIFT;
            div_d = '0;
            bit_d = '0;
          end
          PH_SHIFT: begin
            sck_d = (div_q >= DW'(HALF));
            din_d = sr_q[NB-1];
            if (div_q == DW'(CLK_DIV - 1)) begin
              div_d = '0;
              sr_d  = {sr_q[NB-2:0], 1'b0};
              if (bit_q == BW'(NB - 1)) ph_d = PH_TAIL;
              else                      bit_d = bit_q + BW'(1);
            end else begin
              div_d = div_q + DW'(1);
            end
          end
          default: begin
            if (div_q == DW'(HALF - 1)) begin
              st_d  = S_IDLE_GAP;
              div_d = '0;
            end else begin
              div_d = div_q + DW'(1);
            end
          end
        endcase
      end
      default: begin
        // First gap cycle is the load-rise cycle: busy still high there.
        busy_d = (div_q == '0);
        pd_d   = (div_q == '0) && (idx_q == F_DIG8);
        if (div_q == DW'(HALF - 1)) begin
          start = 1'b1;
          if (pend_q | reinit) begin
            nxt    = 4'd0;
            pend_d = 1'b0;
          end else if (idx_q < F_INIT_LAST) begin
            nxt = idx_q + 4'd1;
          end else if (idx_q == F_INIT_LAST || idx_q == F_INTENS) begin
            nxt = F_DIG1;
          end else if (idx_q < F_DIG8) begin
            nxt = idx_q + 4'd1;
          end else begin
            nxt = (intensity != prog_q) ? F_INTENS : F_DIG1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
    endcase

    if (start) begin
      st_d  = (nxt < F_INTENS) ? S_INIT : S_REFRESH;
      ph_d  = PH_LEAD;
      div_d = '0;
      bit_d = '0;
      idx_d = nxt;
      sr_d  = build_frame(nxt, intensity, (nxt == F_DIG1) ? display_value : disp_q);
      if (nxt == 4'd4 || nxt == F_INTENS) prog_d = intensity;
      if (nxt == F_DIG1)                  disp_d = display_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_POR;
      ph_q   <= PH_LEAD;
      div_q  <= '0;
      bit_q  <= '0;
      por_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      prog_q <= '0;
      din_q  <= 1'b0;
      sck_q  <= 1'b0;
      load_q <= 1'b1;
      busy_q <= 1'b0;
      pd_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      ph_q   <= ph_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      por_q  <= por_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      prog_q <= prog_d;
      din_q  <= din_d;
      sck_q  <= sck_d;
      load_q <= load_d;
      busy_q <= busy_d;
      pd_q   <= pd_d;
    end
  end

  always_ff @(posedge clk) begin
    sr_q   <= sr_d;
    disp_q <= disp_d;
  end

  assign din       = din_q;
  assign sck       = sck_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign pass_done = pd_q;
endmodule

// File: tb/tb_max7219_chain.sv
// Bench for max7219_chain: decodes the serial bus into frames, checks bus
// timing every cycle and compares each frame with a queue of expected frames
// built from the register map and segment table.
module tb_max7219_chain;
  localparam int ND   = 2;
  localparam int CD   = 4;
  localparam int PC   = 16;
  localparam int HALF = CD / 2;
  localparam int NB   = 16 * ND;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [32*ND-1:0] display_value = '0;
  logic [3:0]      intensity = 4'd7;
  logic            reinit = 1'b0;
  logic            din, sck, load, busy, pass_done;

  max7219_chain #(.NUM_DEV(ND), .CLK_DIV(CD), .POR_CYCLES(PC)) dut (
    .clk(clk), .rst(rst), .display_value(display_value), .intensity(intensity),
    .reinit(reinit), .din(din), .sck(sck), .load(load), .busy(busy),
    .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [NB-1:0] expq[$];
  logic [6:0] seg_lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic p_load = 1'b1, p_sck = 1'b0, p_din = 1'b0, p_pd = 1'b0;
  bit in_frame = 0;
  int fbits = 0, fall_cyc = 0, last_edge = 0, last_rise_cyc = -1000;
  int nframes = 0, npd = 0;
  logic [NB-1:0] fval = '0, last_frame = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk_word(input int addr, input int data);
    return 16'((addr << 8) | data);
  endfunction

  function automatic logic [NB-1:0] bcast(input int addr, input int data);
    logic [NB-1:0] f;
    for (int d = 0; d < ND; d++) f[16*d +: 16] = mk_word(addr, data);
    return f;
  endfunction

  function automatic logic [NB-1:0] digit_frame(input logic [32*ND-1:0] v, input int k);
    logic [NB-1:0] f;
    int nib;
    for (int d = 0; d < ND; d++) begin
      nib = int'((v >> (32*d + 4*(k-1))) & 64'hF);
      f[16*d +: 16] = mk_word(k, int'(seg_lut[nib]));
    end
    return f;
  endfunction

  task automatic push_init(input int inten);
    expq.push_back(bcast(12, 0));
    expq.push_back(bcast(15, 0));
    expq.push_back(bcast(11, 7));
    expq.push_back(bcast(9, 0));
    expq.push_back(bcast(10, inten));
    expq.push_back(bcast(12, 1));
  endtask

  task automatic push_pass(input logic [32*ND-1:0] v);
    for (int k = 1; k <= 8; k++) expq.push_back(digit_frame(v, k));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      in_frame = 0;
    end else begin
      if (p_load && !load) begin
        chk("gap_len", 64'((cyc - last_rise_cyc) >= HALF), 1);
        in_frame = 1;
        fbits    = 0;
        fval     = '0;
        fall_cyc = cyc;
      end
      if (!p_sck && sck) begin
        chk("sck_in_load", load, 0);
        chk("sck_low_len", 64'(cyc - ((fbits == 0) ? fall_cyc + 1 : last_edge)), HALF);
        fval = {fval[NB-2:0], din};
        fbits++;
        last_edge = cyc;
      end
      if (p_sck && !sck) begin
        chk("sck_high_len", 64'(cyc - last_edge), HALF);
        last_edge = cyc;
      end
      if (!p_load && load && in_frame) begin
        chk("load_tail", 64'(cyc - last_edge), HALF);
        chk("frame_bits", 64'(fbits), NB);
        chk("frame_expected", 64'(expq.size() > 0), 1);
        if (expq.size() > 0) chk("frame_data", fval, expq.pop_front());
        in_frame      = 0;
        last_rise_cyc = cyc;
        last_frame    = fval;
        nframes++;
      end
      if (pass_done) begin
        npd++;
        chk("pd_width", p_pd, 0);
        chk("pd_after_d8", last_frame[27:24], 8);
        chk("pd_lag", 64'((cyc - last_rise_cyc) <= HALF), 1);
      end
      chk("busy", busy, (!load || !p_load));
      if (din !== p_din) chk("din_edge", sck, 0);
    end
    p_load = load;
    p_sck  = sck;
    p_din  = din;
    p_pd   = pass_done;
  endtask

  task automatic wait_frames(input int target);
    int budget;
    budget = (target - nframes) * 150 + 300;
    while (nframes < target && budget > 0) begin
      tick();
      budget--;
    end
    chk("wait_frames", 64'(nframes), 64'(target));
  endtask

  task automatic wait_load_low();
    int budget;
    budget = 300;
    while (!in_frame && budget > 0) begin
      tick();
      budget--;
    end
    chk("wait_load_low", 64'(in_frame), 1);
  endtask

  task automatic wait_bits(input int n);
    int budget;
    budget = 600;
    while (fbits < n && budget > 0) begin
      tick();
      budget--;
    end
    chk("wait_bits", 64'(fbits), 64'(n));
  endtask

  task automatic por_wait(input bit pulse_reinit);
    int n;
    n = 0;
    while (!in_frame && n < 100) begin
      reinit = pulse_reinit && (n == 5);
      tick();
      n++;
    end
    reinit = 1'b0;
    chk("por_fell", 64'(in_frame), 1);
    chk("por_wait", 64'(n >= PC), 1);
  endtask

  initial begin
    logic [63:0] va, vb, vc;
    va = 64'h0000000F_00000001;
    vb = {$urandom, $urandom};
    vc = {$urandom, $urandom};
    display_value = va;
    intensity     = 4'd7;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_din", din, 0);
    chk("rst_sck", sck, 0);
    chk("rst_load", load, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pass_done", pass_done, 0);

    push_init(7);
    push_pass(va);
    push_pass(va);
    push_pass(vb);
    expq.push_back(bcast(10, 3));
    push_pass(vb);
    for (int k = 1; k <= 3; k++) expq.push_back(digit_frame(vb, k));
    push_init(9);
    push_pass(vb);
    expq.push_back(digit_frame(vb, 1));
    expq.push_back(digit_frame(vb, 2));

    rst = 1'b0;
    por_wait(1'b1);
    wait_frames(1);
    chk("first_word", last_frame, 32'h0C000C00);
    wait_frames(6);
    chk("sixth_word", last_frame, 32'h0C010C01);
    wait_frames(7);
    chk("digit1_known", last_frame, 32'h01470130);

    wait_frames(17);
    wait_load_low();
    repeat (10) tick();
    display_value = vb;

    wait_frames(26);
    wait_load_low();
    repeat (10) tick();
    intensity = 4'd3;
    wait_frames(31);
    chk("intensity_update", last_frame, 32'h0A030A03);

    wait_frames(41);
    wait_load_low();
    wait_bits(10);
    intensity = 4'd9;
    reinit    = 1'b1;
    tick();
    reinit    = 1'b0;
    wait_frames(42);
    chk("reinit_frame_bits", 64'(fbits), NB);
    wait_frames(56);

    wait_frames(58);
    wait_load_low();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    chk("midrst_load", load, 1);
    chk("midrst_sck", sck, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_din", din, 0);
    chk("midrst_pass_done", pass_done, 0);
    rst = 1'b0;
    display_value = vc;
    chk("expq_at_rst", 64'(expq.size()), 0);
    push_init(9);
    push_pass(vc);
    por_wait(1'b0);
    wait_frames(72);
    chk("pass_done_count", 64'(npd), 6);
    chk("expq_drained", 64'(expq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
